// File: rtl/fft_seq_pkg.sv
// Shared types for the FFT frame sequencer: FSM state encoding and config word layout.
package fft_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CONFIG,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } fft_seq_state_t;

    localparam int unsigned CFG_FWD_BIT = 0;

endpackage

// File: rtl/fft_beat_counter.sv
// Modulo-NFFT beat counter; at_last_o flags the final beat position of a frame.
module fft_beat_counter #(
    parameter int unsigned NFFT = 1024
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic inc_i,
    output logic at_last_o
);

    localparam int unsigned CW = $clog2(NFFT);
    localparam logic [CW-1:0] LAST = CW'(NFFT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign at_last_o = (count_q == LAST);

    always_comb begin
        count_d = count_q;
        if (inc_i) begin
            count_d = at_last_o ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frame sequencer in front of a streaming FFT core: per-frame config word, gated sample
// pass-through with tlast generation, and result-stream monitoring for completion/framing errors.
module fft_frame_sequencer
    import fft_seq_pkg::*;
#(
    parameter int unsigned NFFT   = 1024,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CFG_W  = 8,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              start,
    input  logic              stop,
    input  logic [CNT_W-1:0]  num_frames,
    input  logic              fwd_inv,
    input  logic [DATA_W-1:0] in_tdata,
    input  logic              in_tvalid,
    output logic              in_tready,
    output logic [CFG_W-1:0]  cfg_tdata,
    output logic              cfg_tvalid,
    input  logic              cfg_tready,
    output logic [DATA_W-1:0] fft_tdata,
    output logic              fft_tvalid,
    input  logic              fft_tready,
    output logic              fft_tlast,
    input  logic              res_tvalid,
    input  logic              res_tready,
    input  logic              res_tlast,
    output logic              busy,
    output logic              frame_done,
    output logic [CNT_W-1:0]  frames_done,
    output logic              err,
    input  logic              err_clr
);

    fft_seq_state_t   state_q;
    logic [CNT_W-1:0] num_frames_q;
    logic [CNT_W-1:0] frames_done_q;
    logic [CFG_W-1:0] cfg_tdata_q;
    logic             stop_pending_q;
    logic             cfg_tvalid_q;
    logic             busy_q;
    logic             frame_done_q;
    logic             err_q;

    logic streaming;
    logic in_hs;
    logic res_hs;
    logic in_last;
    logic res_last;
    logic err_set;
    logic run_over;

    function automatic logic [CFG_W-1:0] cfg_word(input logic fwd);
        logic [CFG_W-1:0] w;
        w = '0;
        w[CFG_FWD_BIT] = fwd;
        return w;
    endfunction

    // Data path is a zero-latency pass-through, gated by the STREAM state.
    assign streaming  = (state_q == ST_STREAM);
    assign fft_tvalid = streaming & in_tvalid;
    assign in_tready  = streaming & fft_tready;
    assign fft_tdata  = in_tdata;
    assign fft_tlast  = streaming & in_last;
    assign in_hs      = fft_tvalid & fft_tready;

    assign res_hs  = res_tvalid & res_tready;
    assign err_set = res_hs & (res_tlast ^ res_last);

    // stop arriving in the DONE cycle itself still ends the run there.
    assign run_over = stop_pending_q | stop |
                      ((num_frames_q != '0) && (frames_done_q == num_frames_q));

    fft_beat_counter #(.NFFT(NFFT)) u_in_cnt (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .inc_i     (in_hs),
        .at_last_o (in_last)
    );

    fft_beat_counter #(.NFFT(NFFT)) u_res_cnt (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .inc_i     (res_hs),
        .at_last_o (res_last)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q        <= ST_IDLE;
            num_frames_q   <= '0;
            frames_done_q  <= '0;
            cfg_tdata_q    <= '0;
            stop_pending_q <= 1'b0;
            cfg_tvalid_q   <= 1'b0;
            busy_q         <= 1'b0;
            frame_done_q   <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (stop && (state_q != ST_IDLE)) begin
                stop_pending_q <= 1'b1;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q        <= ST_CONFIG;
                        num_frames_q   <= num_frames;
                        frames_done_q  <= '0;
                        stop_pending_q <= 1'b0;
                        busy_q         <= 1'b1;
                        cfg_tvalid_q   <= 1'b1;
                        cfg_tdata_q    <= cfg_word(fwd_inv);
                    end
                end
                ST_CONFIG: begin
                    if (cfg_tready) begin
                        state_q      <= ST_STREAM;
                        cfg_tvalid_q <= 1'b0;
                    end
                end
                ST_STREAM: begin
                    if (in_hs && in_last) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (res_hs && (res_tlast || res_last)) begin
                        state_q       <= ST_DONE;
                        frame_done_q  <= 1'b1;
                        frames_done_q <= frames_done_q + CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    if (run_over) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        state_q      <= ST_CONFIG;
                        cfg_tvalid_q <= 1'b1;
                        cfg_tdata_q  <= cfg_word(fwd_inv);
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cfg_tvalid  = cfg_tvalid_q;
    assign cfg_tdata   = cfg_tdata_q;
    assign busy        = busy_q;
    assign frame_done  = frame_done_q;
    assign frames_done = frames_done_q;
    assign err         = err_q;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Randomized self-checking bench for fft_frame_sequencer (NFFT=8 main instance, NFFT=1024 regression instance).
module tb_fft_frame_sequencer;

    localparam int unsigned NFFT   = 8;
    localparam int unsigned BIG_N  = 1024;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CFG_W  = 8;
    localparam int unsigned CNT_W  = 16;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic              aresetn, start, stop, fwd_inv, err_clr;
    logic [CNT_W-1:0]  num_frames;
    logic [DATA_W-1:0] in_tdata;
    logic              in_tvalid, in_tready;
    logic [CFG_W-1:0]  cfg_tdata;
    logic              cfg_tvalid, cfg_tready;
    logic [DATA_W-1:0] fft_tdata;
    logic              fft_tvalid, fft_tready, fft_tlast;
    logic              res_tvalid, res_tready, res_tlast;
    logic              busy, frame_done, err;
    logic [CNT_W-1:0]  frames_done;

    logic              b_start, b_stop, b_fwd_inv, b_err_clr;
    logic [CNT_W-1:0]  b_num_frames;
    logic [DATA_W-1:0] b_in_tdata;
    logic              b_in_tvalid, b_in_tready;
    logic [CFG_W-1:0]  b_cfg_tdata;
    logic              b_cfg_tvalid, b_cfg_tready;
    logic [DATA_W-1:0] b_fft_tdata;
    logic              b_fft_tvalid, b_fft_tready, b_fft_tlast;
    logic              b_res_tvalid, b_res_tready, b_res_tlast;
    logic              b_busy, b_frame_done, b_err;
    logic [CNT_W-1:0]  b_frames_done;

    fft_frame_sequencer #(.NFFT(NFFT), .DATA_W(DATA_W), .CFG_W(CFG_W), .CNT_W(CNT_W)) u_dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .stop(stop), .num_frames(num_frames),
        .fwd_inv(fwd_inv), .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready),
        .cfg_tdata(cfg_tdata), .cfg_tvalid(cfg_tvalid), .cfg_tready(cfg_tready),
        .fft_tdata(fft_tdata), .fft_tvalid(fft_tvalid), .fft_tready(fft_tready), .fft_tlast(fft_tlast),
        .res_tvalid(res_tvalid), .res_tready(res_tready), .res_tlast(res_tlast),
        .busy(busy), .frame_done(frame_done), .frames_done(frames_done), .err(err), .err_clr(err_clr)
    );

    fft_frame_sequencer #(.NFFT(BIG_N), .DATA_W(DATA_W), .CFG_W(CFG_W), .CNT_W(CNT_W)) u_dut_big (
        .aclk(aclk), .aresetn(aresetn), .start(b_start), .stop(b_stop), .num_frames(b_num_frames),
        .fwd_inv(b_fwd_inv), .in_tdata(b_in_tdata), .in_tvalid(b_in_tvalid), .in_tready(b_in_tready),
        .cfg_tdata(b_cfg_tdata), .cfg_tvalid(b_cfg_tvalid), .cfg_tready(b_cfg_tready),
        .fft_tdata(b_fft_tdata), .fft_tvalid(b_fft_tvalid), .fft_tready(b_fft_tready), .fft_tlast(b_fft_tlast),
        .res_tvalid(b_res_tvalid), .res_tready(b_res_tready), .res_tlast(b_res_tlast),
        .busy(b_busy), .frame_done(b_frame_done), .frames_done(b_frames_done), .err(b_err), .err_clr(b_err_clr)
    );

    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;

    // Stimulus knobs
    int cfg_stall, bp_mode, valid_pct, res_len, res_tlast_idx, stop_at_sample, abort_at;
    bit stop_on_fd;

    // Observations collected by run()
    logic [DATA_W-1:0] src_q[$];
    logic [DATA_W:0]   acc_q[$];
    logic [CFG_W-1:0]  cfg_q[$];
    int                cfg_hold_q[$];
    int                fd_count, bad_fd_gap, bad_cfg_gap;
    bit                timed_out, start_ok;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 0; stop = 0; err_clr = 0; in_tvalid = 0; in_tdata = '0;
        cfg_tready = 0; fft_tready = 0; res_tvalid = 0; res_tready = 0; res_tlast = 0;
    endtask

    task automatic set_defaults();
        cfg_stall = 0; bp_mode = 0; valid_pct = 100; res_len = NFFT; res_tlast_idx = NFFT - 1;
        stop_at_sample = -1; abort_at = -1; stop_on_fd = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        aresetn = 0;
        tick(); tick();
        aresetn = 1;
        tick();
    endtask

    // Drives one run (start pulse through return to idle) with a behavioural FFT stand-in.
    task automatic run(input logic [CNT_W-1:0] nf, input logic fwd, input int max_cycles);
        int hold, res_left, res_idx, src_idx, last_res_cyc, fd_cyc;
        bit toggle, stop_sent, prev_cfg_v, done;
        src_q.delete(); acc_q.delete(); cfg_q.delete(); cfg_hold_q.delete();
        fd_count = 0; bad_fd_gap = 0; bad_cfg_gap = 0; timed_out = 0;
        hold = 0; res_left = 0; res_idx = 0; src_idx = 0; last_res_cyc = -10; fd_cyc = -10;
        toggle = 1; stop_sent = 0; done = 0; prev_cfg_v = 0;
        num_frames = nf; fwd_inv = fwd; start = 1;
        tick();
        start = 0;
        start_ok = busy && cfg_tvalid;
        for (int cyc = 0; cyc < max_cycles; cyc++) begin
            cfg_tready = cfg_tvalid && (hold >= cfg_stall);
            case (bp_mode)
                0:       fft_tready = 1;
                1:       fft_tready = toggle;
                default: fft_tready = 1'($urandom_range(0, 1));
            endcase
            toggle = ~toggle;
            in_tvalid = ($urandom_range(0, 99) < valid_pct);
            if (src_q.size() <= src_idx) src_q.push_back($urandom);
            in_tdata = src_q[src_idx];
            res_tready = 1;
            res_tvalid = (res_left > 0) && ($urandom_range(0, 3) != 0);
            res_tlast = res_tvalid && (res_idx == res_tlast_idx);
            stop = !stop_sent && (((stop_at_sample >= 0) && (src_idx == stop_at_sample)) ||
                                  (stop_on_fd && frame_done));
            if (stop) stop_sent = 1;
            #1;
            if (frame_done) begin
                fd_count++;
                fd_cyc = cyc;
                if (cyc != last_res_cyc + 1) bad_fd_gap++;
            end
            if (cfg_tvalid && !prev_cfg_v && fd_count > 0 && cyc != fd_cyc + 1) bad_cfg_gap++;
            prev_cfg_v = cfg_tvalid;
            if (cfg_tvalid) hold++;
            if (cfg_tvalid && cfg_tready) begin
                cfg_q.push_back(cfg_tdata);
                cfg_hold_q.push_back(hold);
                hold = 0;
            end
            if (res_tvalid && res_tready) begin
                res_left--; res_idx++; last_res_cyc = cyc;
            end
            if (fft_tvalid && fft_tready) begin
                acc_q.push_back({fft_tlast, fft_tdata});
                if (fft_tlast) begin res_left = res_len; res_idx = 0; end
            end
            if (in_tvalid && in_tready) src_idx++;
            if (abort_at >= 0 && acc_q.size() == abort_at) begin done = 1; break; end
            tick();
            stop = 0;
            if (!busy) begin done = 1; break; end
        end
        if (!done) timed_out = 1;
        stop = 0; in_tvalid = 0; res_tvalid = 0; res_tlast = 0; cfg_tready = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        aresetn = 0;
        in_tvalid = 1; fft_tready = 1; start = 1;
        tick(); tick();
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (cfg_tvalid !== 1'b0 || cfg_tdata !== '0) begin n_fail++; $display("FAIL reset_cfg: got v=%b d=%h want 0/00", cfg_tvalid, cfg_tdata); end
        n_cmp++; if ({fft_tvalid, fft_tlast, in_tready} !== 3'b000) begin n_fail++; $display("FAIL reset_stream: got %b want 000", {fft_tvalid, fft_tlast, in_tready}); end
        n_cmp++; if (frame_done !== 1'b0 || err !== 1'b0 || frames_done !== '0) begin n_fail++; $display("FAIL reset_status: got fd=%b err=%b cnt=%0d want 0/0/0", frame_done, err, frames_done); end
        idle_inputs();
        aresetn = 1;
        tick();
    endtask

    task automatic check_frames(input string name, input int n);
        // Every accepted sample must be the next source sample, with tlast only on each frame's last one.
        logic [DATA_W:0] exp;
        n_cmp++; if (acc_q.size() != n * NFFT) begin n_fail++; $display("FAIL %s_count: got %0d samples want %0d", name, acc_q.size(), n * NFFT); end
        for (int i = 0; i < acc_q.size() && i < src_q.size(); i++) begin
            exp = {((i % NFFT) == NFFT - 1), src_q[i]};
            n_cmp++; if (acc_q[i] !== exp) begin n_fail++; $display("FAIL %s_sample%0d: got %h want %h", name, i, acc_q[i], exp); end
        end
    endtask

    task automatic test_single();
        set_defaults();
        run(1, 1, 300);
        n_cmp++; if (timed_out !== 0) begin n_fail++; $display("FAIL single_timeout: got %b want 0", timed_out); end
        n_cmp++; if (start_ok !== 1) begin n_fail++; $display("FAIL single_start_latency: got %b want 1", start_ok); end
        n_cmp++; if (cfg_q.size() != 1 || cfg_q[0] !== 8'h01) begin n_fail++; $display("FAIL single_cfg: got n=%0d w=%h want 1/01", cfg_q.size(), cfg_q.size() ? cfg_q[0] : '0); end
        check_frames("single", 1);
        n_cmp++; if (fd_count != 1 || frames_done !== 16'd1) begin n_fail++; $display("FAIL single_done: got pulses=%0d cnt=%0d want 1/1", fd_count, frames_done); end
        n_cmp++; if (busy !== 0 || err !== 0) begin n_fail++; $display("FAIL single_idle: got busy=%b err=%b want 0/0", busy, err); end
        n_cmp++; if (bad_fd_gap != 0) begin n_fail++; $display("FAIL single_fd_timing: got %0d late pulses want 0", bad_fd_gap); end
    endtask

    task automatic test_backpressure();
        set_defaults();
        cfg_stall = 3; bp_mode = 1; valid_pct = 70;
        run(1, 1, 400);
        n_cmp++; if (timed_out !== 0) begin n_fail++; $display("FAIL bp_timeout: got %b want 0", timed_out); end
        n_cmp++; if (cfg_hold_q.size() != 1 || cfg_hold_q[0] != 4) begin n_fail++; $display("FAIL bp_cfg_hold: got %0d cycles want 4", cfg_hold_q.size() ? cfg_hold_q[0] : -1); end
        check_frames("bp", 1);
        n_cmp++; if (frames_done !== 16'd1) begin n_fail++; $display("FAIL bp_frames: got %0d want 1", frames_done); end
    endtask

    task automatic test_multi();
        set_defaults();
        cfg_stall = $urandom_range(0, 2); bp_mode = 2; valid_pct = 80;
        run(3, 0, 1500);
        n_cmp++; if (timed_out !== 0) begin n_fail++; $display("FAIL multi_timeout: got %b want 0", timed_out); end
        n_cmp++; if (cfg_q.size() != 3) begin n_fail++; $display("FAIL multi_cfg_count: got %0d want 3", cfg_q.size()); end
        for (int i = 0; i < cfg_q.size(); i++) begin
            n_cmp++; if (cfg_q[i] !== 8'h00 || cfg_hold_q[i] != cfg_stall + 1) begin n_fail++; $display("FAIL multi_cfg%0d: got %h/%0d want 00/%0d", i, cfg_q[i], cfg_hold_q[i], cfg_stall + 1); end
        end
        check_frames("multi", 3);
        n_cmp++; if (fd_count != 3 || frames_done !== 16'd3 || busy !== 0) begin n_fail++; $display("FAIL multi_done: got pulses=%0d cnt=%0d busy=%b want 3/3/0", fd_count, frames_done, busy); end
        n_cmp++; if (bad_fd_gap != 0 || bad_cfg_gap != 0) begin n_fail++; $display("FAIL multi_gaps: got fd=%0d cfg=%0d want 0/0", bad_fd_gap, bad_cfg_gap); end
    endtask

    task automatic test_continuous_stop();
        set_defaults();
        valid_pct = 90;
        stop_at_sample = NFFT + 3;
        run(0, 1, 1500);
        n_cmp++; if (timed_out !== 0) begin n_fail++; $display("FAIL cont_timeout: got %b want 0", timed_out); end
        check_frames("cont", 2);
        n_cmp++; if (frames_done !== 16'd2 || fd_count != 2 || busy !== 0) begin n_fail++; $display("FAIL cont_done: got cnt=%0d pulses=%0d busy=%b want 2/2/0", frames_done, fd_count, busy); end
        set_defaults();
        stop_on_fd = 1;
        run(0, 1, 1500);
        n_cmp++; if (timed_out !== 0 || frames_done !== 16'd1 || cfg_q.size() != 1) begin n_fail++; $display("FAIL stop_in_done: got cnt=%0d cfgs=%0d to=%b want 1/1/0", frames_done, cfg_q.size(), timed_out); end
    endtask

    task automatic test_framing_error();
        do_reset();
        set_defaults();
        res_len = 6; res_tlast_idx = 5;
        run(1, 1, 300);
        n_cmp++; if (err !== (res_tlast_idx != NFFT - 1) || fd_count != 1 || frames_done !== 16'd1) begin n_fail++; $display("FAIL early_tlast: got err=%b pulses=%0d cnt=%0d want 1/1/1", err, fd_count, frames_done); end
        tick(); tick();
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky: got %b want 1", err); end
        err_clr = 1; tick(); err_clr = 0;
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clr: got %b want 0", err); end
        do_reset();
        set_defaults();
        res_tlast_idx = -1;
        run(1, 0, 300);
        n_cmp++; if (err !== 1'b1 || fd_count != 1 || timed_out !== 0) begin n_fail++; $display("FAIL missing_tlast: got err=%b pulses=%0d to=%b want 1/1/0", err, fd_count, timed_out); end
        do_reset();
    endtask

    task automatic test_reset_midstream();
        set_defaults();
        abort_at = 4;
        run(1, 1, 300);
        n_cmp++; if (acc_q.size() != 4) begin n_fail++; $display("FAIL abort_point: got %0d samples want 4", acc_q.size()); end
        in_tvalid = 1; fft_tready = 1; cfg_tready = 1;
        #2;
        aresetn = 0;
        #1;
        n_cmp++; if ({busy, cfg_tvalid, in_tready, fft_tvalid, fft_tlast, frame_done} !== 6'b0 || frames_done !== '0) begin n_fail++; $display("FAIL async_reset: got %b cnt=%0d want 000000/0", {busy, cfg_tvalid, in_tready, fft_tvalid, fft_tlast, frame_done}, frames_done); end
        tick();
        idle_inputs();
        aresetn = 1;
        tick();
        set_defaults();
        run(1, 1, 300);
        check_frames("after_reset", 1);
        n_cmp++; if (frames_done !== 16'd1 || err !== 0 || timed_out !== 0) begin n_fail++; $display("FAIL after_reset_done: got cnt=%0d err=%b to=%b want 1/0/0", frames_done, err, timed_out); end
    endtask

    function automatic logic [DATA_W-1:0] tone(input int i);
        // Coarse quadrature ramp standing in for a sampled sinusoid.
        return {16'(i * 13), 16'(i * 97)};
    endfunction

    task automatic test_nfft1024();
        int n, res_left;
        int tl_idx[$];
        bit done;
        n = 0; res_left = 0; done = 0;
        b_num_frames = 2; b_fwd_inv = 1; b_cfg_tready = 1; b_fft_tready = 1; b_res_tready = 1;
        b_in_tvalid = 1; b_in_tdata = tone(0); b_start = 1;
        tick();
        b_start = 0;
        for (int cyc = 0; cyc < 6000; cyc++) begin
            b_res_tvalid = (res_left > 0);
            b_res_tlast = (res_left == 1);
            b_in_tdata = tone(n);
            #1;
            if (b_res_tvalid && b_res_tready) res_left--;
            if (b_fft_tvalid && b_fft_tready) begin
                if (b_fft_tlast) begin tl_idx.push_back(n); res_left = BIG_N; end
                n++;
            end
            tick();
            if (!b_busy) begin done = 1; break; end
        end
        b_in_tvalid = 0; b_res_tvalid = 0; b_res_tlast = 0;
        n_cmp++; if (!done) begin n_fail++; $display("FAIL big_timeout: got busy=%b want 0", b_busy); end
        n_cmp++; if (tl_idx.size() != 2 || n != 2 * BIG_N) begin n_fail++; $display("FAIL big_tlast_count: got %0d tlasts / %0d samples want 2/%0d", tl_idx.size(), n, 2 * BIG_N); end
        n_cmp++; if (tl_idx.size() < 2 || tl_idx[0] != BIG_N - 1 || tl_idx[1] != 2 * BIG_N - 1) begin n_fail++; $display("FAIL big_tlast_pos: got %0d,%0d want 1023,2047", tl_idx.size() > 0 ? tl_idx[0] : -1, tl_idx.size() > 1 ? tl_idx[1] : -1); end
        n_cmp++; if (b_frames_done !== 16'd2 || b_err !== 0) begin n_fail++; $display("FAIL big_done: got cnt=%0d err=%b want 2/0", b_frames_done, b_err); end
    endtask

    initial begin
        b_start = 0; b_stop = 0; b_fwd_inv = 0; b_err_clr = 0; b_num_frames = '0;
        b_in_tdata = '0; b_in_tvalid = 0; b_cfg_tready = 0; b_fft_tready = 0;
        b_res_tvalid = 0; b_res_tready = 0; b_res_tlast = 0;
        num_frames = '0; fwd_inv = 0;
        set_defaults();
        test_reset();
        test_single();
        test_backpressure();
        test_multi();
        test_continuous_stop();
        test_framing_error();
        test_reset_midstream();
        test_nfft1024();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_frame_sequencer.md
# fft_frame_sequencer

Controller sitting in front of the streaming FFT core. Sequences frame processing: issues a per-frame direction config word on the FFT config channel, gates a sample source into the FFT data channel, generates `tlast` on sample NFFT-1, and monitors the FFT result stream to detect frame completion and framing errors. Supports a programmed frame count or continuous operation until stopped.

## Interface
Parameters:
- `NFFT`, 1024: samples per frame, power of two, at least 4.
- `DATA_W`, 32: sample width, {imag[31:16], real[15:0]}.
- `CFG_W`, 8: config word width.
- `CNT_W`, 16: frame counter width.

Ports:
- `aclk`  in  1  clock; all logic on rising edge.
- `aresetn`  in  1  reset. One clock; reset is asynchronous and active-low.
- `start`  in  1  one-cycle pulse; begins a run; ignored unless idle.
- `stop`  in  1  one-cycle pulse; ends the run at the next frame boundary.
- `num_frames`  in  CNT_W  frames per run, sampled on `start`; 0 = continuous.
- `fwd_inv`  in  1  1 = forward, 0 = inverse; sampled at CONFIG entry.
- `in_tdata` / `in_tvalid` / `in_tready`  in / in / out  DATA_W / 1 / 1  sample source stream.
- `cfg_tdata` / `cfg_tvalid` / `cfg_tready`  out / out / in  CFG_W / 1 / 1  FFT config channel.
- `fft_tdata` / `fft_tvalid` / `fft_tready` / `fft_tlast`  out / out / in / out  DATA_W / 1 / 1 / 1  FFT data input channel.
- `res_tvalid` / `res_tready` / `res_tlast`  in  1 each  FFT result handshake monitor; observe only.
- `busy`  out  1  high in any state other than IDLE.
- `frame_done`  out  1  one-cycle pulse per completed frame.
- `frames_done`  out  CNT_W  frames completed in the current run; wraps.
- `err`  out  1  sticky framing error.
- `err_clr`  in  1  clears `err`.

## Operation
- States: IDLE, CONFIG, STREAM, DRAIN, DONE.
- IDLE: `start` latches `num_frames`, clears `frames_done` and stop_pending, goes to CONFIG.
- CONFIG: `cfg_tvalid`=1; `cfg_tdata`={zeros, fwd_inv}, with bit 0 holding `fwd_inv` registered on entry. On `cfg_tvalid & cfg_tready`, go to STREAM.
- STREAM: combinational pass-through. `fft_tvalid`=`in_tvalid`, `in_tready`=`fft_tready`, `fft_tdata`=`in_tdata`. The input counter increments on each `fft_tvalid & fft_tready`. `fft_tlast`=1 when the counter equals NFFT-1. On the last handshake, the counter wraps to 0 and the state goes to DRAIN.
- Outside STREAM: `in_tready`=0, `fft_tvalid`=0, `fft_tlast`=0.
- DRAIN: the output counter increments on each `res_tvalid & res_tready`. A beat with `res_tlast`, or a beat with the counter at NFFT-1, ends the frame and moves to DONE.
- Framing error: `res_tlast` on a beat whose counter is not NFFT-1, or counter at NFFT-1 with `res_tlast`=0. Either case sets `err`. The frame still completes.
- Result beats seen outside DRAIN are counted and also checked for framing errors.
- DONE, lasting one cycle: `frame_done`=1, `frames_done`++. Next state is IDLE if stop_pending, or if `num_frames`≠0 and the new count equals `num_frames`. Otherwise the next state is CONFIG.
- `stop` sets stop_pending in any non-IDLE state. In IDLE it has no effect.
- `err_clr` clears `err`. If a new error occurs in the same cycle, the set wins.

## Timing
- Reset values: state IDLE; `cfg_tvalid`, `cfg_tdata`, `fft_tvalid`, `fft_tlast`, `in_tready`, `busy`, `frame_done`, `err` all 0; `frames_done` 0; both counters 0.
- `start` at cycle t: `busy` and `cfg_tvalid` are high at t+1.
- Config accepted at cycle c: `in_tready` can be high at c+1.
- Data path has zero latency. `cfg_tvalid` stays held until accepted.
- Last result beat at cycle r: `frame_done` pulses at r+1; next `cfg_tvalid` at r+2.
- Reset asserted mid-frame aborts immediately to reset values. No partial frame is completed.
- A `start` pulse while busy is ignored.
- Simultaneous `stop` and a DONE cycle: the current DONE exits to IDLE.

## Structure
- Package `fft_seq_pkg` holds the state enum `fft_seq_state_t` and the config bit index `CFG_FWD_BIT`=0.
- Sub-module `fft_beat_counter` (NFFT-modulo counter with an `at_last` flag), instantiated twice: once for input beats, once for result beats.

## Test plan
Sim runs use NFFT=8 unless noted.
- Single forward frame: `num_frames`=1, `fwd_inv`=1, all ready signals high, 8 samples -> `cfg_tdata`=8'h01, `fft_tlast` on the 8th sample only, 8 result beats with tlast on the last -> one `frame_done`, `frames_done`=1, back to IDLE, `err`=0.
- Backpressure: `fft_tready` toggled 1-0-1-0…, `cfg_tready` low for 3 cycles -> `cfg_tvalid` held 4 cycles; no sample dropped or duplicated; `fft_tlast` aligned with the 8th accepted sample.
- Multi/continuous: `num_frames`=3 with `fwd_inv`=0 -> 3 config words 8'h00, `frames_done`=3, then IDLE. `num_frames`=0 with `stop` in frame 2 -> frame 2 completes, then IDLE with `frames_done`=2.
- Framing error: `res_tlast` on beat 6 -> `err`=1, `frame_done` pulses. `err_clr` -> `err`=0. Beat 8 without tlast -> `err`=1.
- Reset mid-STREAM after 4 samples -> all outputs at reset values; a new `start` produces a full 8-sample frame with tlast on sample 8.
- NFFT=1024 regression: 2 frames of a sine stream -> tlast at sample indices 1023 and 2047.
